// File: rtl/bp_common_cfg_link_pkg.sv
// Config-link definitions shared by the config-bus initiator and the per-tile responder:
// processor parameter sets, the register address map and the request record.
package bp_common_cfg_link_pkg;

  typedef enum logic [0:0] {
    e_bp_single_core_cfg = 1'b0,
    e_bp_dual_core_cfg   = 1'b1
  } bp_params_e;

  typedef struct packed {
    int num_core;
    int vaddr_width;
    int cfg_core_width;
    int cfg_addr_width;
    int cfg_data_width;
  } bp_proc_param_s;

  // Link field widths are common to every configuration so the request record is fixed
  localparam int cfg_core_width_gp = 8;
  localparam int cfg_addr_width_gp = 16;
  localparam int cfg_data_width_gp = 64;

  // Element [1] is the dual-core set, element [0] the single-core set
  localparam bp_proc_param_s [1:0] all_cfgs_gp = {
    bp_proc_param_s'{num_core: 2, vaddr_width: 39, cfg_core_width: cfg_core_width_gp,
                     cfg_addr_width: cfg_addr_width_gp, cfg_data_width: cfg_data_width_gp},
    bp_proc_param_s'{num_core: 1, vaddr_width: 39, cfg_core_width: cfg_core_width_gp,
                     cfg_addr_width: cfg_addr_width_gp, cfg_data_width: cfg_data_width_gp}
  };

  typedef enum logic [3:0] {
    e_cfg_freeze       = 4'h0,
    e_cfg_npc          = 4'h1,
    e_cfg_icache_mode  = 4'h2,
    e_cfg_dcache_mode  = 4'h3,
    e_cfg_cce_mode     = 4'h4,
    e_cfg_scratch      = 4'h5,
    e_cfg_err          = 4'h6
  } bp_cfg_addr_e;

  typedef struct packed {
    logic                         w_v;
    logic [cfg_core_width_gp-1:0] core;
    logic [cfg_addr_width_gp-1:0] addr;
    logic [cfg_data_width_gp-1:0] data;
  } bp_cfg_req_s;

endpackage

// File: rtl/bp_cfg_responder.sv
// Per-tile configuration register slave: decodes config-bus writes/reads addressed to this
// core (or broadcast writes), drives core control outputs and returns one read response at a time.
module bp_cfg_responder
  import bp_common_cfg_link_pkg::*;
#(
  parameter bp_params_e cfg_p = e_bp_single_core_cfg,
  localparam bp_proc_param_s proc_param_lp = all_cfgs_gp[cfg_p],
  localparam int vaddr_width_lp = proc_param_lp.vaddr_width,
  localparam int cfg_core_width_lp = proc_param_lp.cfg_core_width,
  localparam int cfg_addr_width_lp = proc_param_lp.cfg_addr_width,
  localparam int cfg_data_width_lp = proc_param_lp.cfg_data_width
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [cfg_core_width_lp-1:0] my_core_id_i,

  input  logic                         cfg_v_i,
  output logic                         cfg_ready_o,
  input  logic                         cfg_w_v_i,
  input  logic [cfg_core_width_lp-1:0] cfg_core_i,
  input  logic [cfg_addr_width_lp-1:0] cfg_addr_i,
  input  logic [cfg_data_width_lp-1:0] cfg_data_i,

  output logic                         resp_v_o,
  input  logic                         resp_ready_i,
  output logic [cfg_data_width_lp-1:0] resp_data_o,

  output logic                         freeze_o,
  output logic [vaddr_width_lp-1:0]    npc_o,
  output logic                         npc_w_v_o,
  output logic [1:0]                   icache_mode_o,
  output logic [1:0]                   dcache_mode_o,
  output logic                         cce_mode_o,
  output logic                         err_o
);

  typedef enum logic {e_ready, e_resp} state_e;

  state_e                         state_r;
  logic                           cfg_ready_r;
  logic                           resp_v_r;
  logic [cfg_data_width_lp-1:0]   resp_data_p1;

  logic                           freeze_r;
  logic [vaddr_width_lp-1:0]      npc_r;
  logic                           npc_w_v_r;
  logic [1:0]                     icache_mode_r;
  logic [1:0]                     dcache_mode_r;
  logic                           cce_mode_r;
  logic [cfg_data_width_lp-1:0]   scratch_r;
  logic                           err_r;

  bp_cfg_req_s                    req;
  bp_cfg_addr_e                   addr_e;
  logic                           accept, bcast, hit, mapped, wr_hit, rd_hit;
  logic [cfg_data_width_lp-1:0]   rd_data;

  assign req = '{
    w_v:  cfg_w_v_i,
    core: cfg_core_width_gp'(cfg_core_i),
    addr: cfg_addr_width_gp'(cfg_addr_i),
    data: cfg_data_width_gp'(cfg_data_i)
  };

  // Broadcast only reaches writes; a broadcast read is swallowed without a response
  assign accept = cfg_v_i & cfg_ready_r;
  assign bcast  = &req.core;
  assign hit    = (req.core == cfg_core_width_gp'(my_core_id_i)) | (bcast & req.w_v);
  assign wr_hit = accept & hit & req.w_v;
  assign rd_hit = accept & hit & ~req.w_v;

  assign addr_e = bp_cfg_addr_e'(req.addr[3:0]);
  assign mapped = (req.addr[cfg_addr_width_gp-1:4] == '0) && (req.addr[3:0] <= e_cfg_err);

  always_comb begin
    rd_data = '0;
    if (mapped) begin
      case (addr_e)
        e_cfg_freeze:      rd_data[0]   = freeze_r;
        e_cfg_npc:         rd_data      = cfg_data_width_lp'(npc_r);
        e_cfg_icache_mode: rd_data[1:0] = icache_mode_r;
        e_cfg_dcache_mode: rd_data[1:0] = dcache_mode_r;
        e_cfg_cce_mode:    rd_data[0]   = cce_mode_r;
        e_cfg_scratch:     rd_data      = scratch_r;
        e_cfg_err:         rd_data[0]   = err_r;
        default:           rd_data      = '0;
      endcase
    end
  end

  // Request decode / register update / response hold
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= e_ready;
      cfg_ready_r   <= 1'b0;
      resp_v_r      <= 1'b0;
      resp_data_p1  <= '0;
      freeze_r      <= 1'b1;
      npc_r         <= '0;
      npc_w_v_r     <= 1'b0;
      icache_mode_r <= 2'b00;
      dcache_mode_r <= 2'b00;
      cce_mode_r    <= 1'b0;
      scratch_r     <= '0;
      err_r         <= 1'b0;
    end else begin
      npc_w_v_r <= 1'b0;
      case (state_r)
        e_ready: begin
          cfg_ready_r <= 1'b1;
          if (wr_hit) begin
            if (!mapped) begin
              err_r <= 1'b1;
            end else begin
              case (addr_e)
                e_cfg_freeze: freeze_r <= req.data[0];
                e_cfg_npc: begin
                  npc_r     <= req.data[vaddr_width_lp-1:0];
                  npc_w_v_r <= 1'b1;
                end
                e_cfg_icache_mode: icache_mode_r <= req.data[1:0];
                e_cfg_dcache_mode: dcache_mode_r <= req.data[1:0];
                e_cfg_cce_mode:    cce_mode_r    <= req.data[0];
                e_cfg_scratch:     scratch_r     <= req.data;
                e_cfg_err:         err_r         <= 1'b0;
                default: ;
              endcase
            end
          end
          if (rd_hit) begin
            if (!mapped) err_r <= 1'b1;
            resp_data_p1 <= rd_data;
            resp_v_r     <= 1'b1;
            cfg_ready_r  <= 1'b0;
            state_r      <= e_resp;
          end
        end
        e_resp: begin
          if (resp_ready_i) begin
            resp_v_r    <= 1'b0;
            cfg_ready_r <= 1'b1;
            state_r     <= e_ready;
          end
        end
        default: state_r <= e_ready;
      endcase
    end
  end

  assign cfg_ready_o   = cfg_ready_r;
  assign resp_v_o      = resp_v_r;
  assign resp_data_o   = resp_data_p1;
  assign freeze_o      = freeze_r;
  assign npc_o         = npc_r;
  assign npc_w_v_o     = npc_w_v_r;
  assign icache_mode_o = icache_mode_r;
  assign dcache_mode_o = dcache_mode_r;
  assign cce_mode_o    = cce_mode_r;
  assign err_o         = err_r;

endmodule

// File: tb/tb_bp_cfg_responder.sv
// Bench for bp_cfg_responder: vector table of config accesses plus hand-built stall,
// throughput and reset sequences; read responses are matched against a queue of expected data.
module tb_bp_cfg_responder;
  import bp_common_cfg_link_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  my_core_id;
  logic        cfg_v, cfg_ready, cfg_w_v;
  logic [7:0]  cfg_core;
  logic [15:0] cfg_addr;
  logic [63:0] cfg_data;
  logic        resp_v, resp_ready;
  logic [63:0] resp_data;
  logic        freeze, npc_w_v, cce_mode, err;
  logic [38:0] npc;
  logic [1:0]  icache_mode, dcache_mode;

  always #5 clk = ~clk;

  bp_cfg_responder #(.cfg_p(e_bp_single_core_cfg)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .my_core_id_i(my_core_id),
    .cfg_v_i(cfg_v), .cfg_ready_o(cfg_ready), .cfg_w_v_i(cfg_w_v),
    .cfg_core_i(cfg_core), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .resp_v_o(resp_v), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .freeze_o(freeze), .npc_o(npc), .npc_w_v_o(npc_w_v),
    .icache_mode_o(icache_mode), .dcache_mode_o(dcache_mode),
    .cce_mode_o(cce_mode), .err_o(err)
  );

  typedef enum {CHK_NONE, CHK_FREEZE, CHK_NPC, CHK_ICACHE, CHK_DCACHE,
                CHK_CCE, CHK_ERR, CHK_READY} chk_e;

  typedef struct {
    bit          w;
    logic [7:0]  core;
    logic [15:0] addr;
    logic [63:0] data;
    bit          exp_resp;
    chk_e        chk;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response scoreboard: every handshaken response must match the oldest expected entry
  always @(negedge clk) begin
    if (reset_n === 1'b1 && resp_v === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got response data 0x%0h, expected no response", resp_data);
      end else begin
        check("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [63:0] out_of(input chk_e c);
    case (c)
      CHK_FREEZE: return {63'b0, freeze};
      CHK_NPC:    return 64'(npc);
      CHK_ICACHE: return {62'b0, icache_mode};
      CHK_DCACHE: return {62'b0, dcache_mode};
      CHK_CCE:    return {63'b0, cce_mode};
      CHK_ERR:    return {63'b0, err};
      CHK_READY:  return {63'b0, cfg_ready};
      default:    return 64'b0;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge with cfg_v dropped
  task automatic send(input bit w, input logic [7:0] core, input logic [15:0] addr,
                      input logic [63:0] data);
    cfg_v = 1'b1; cfg_w_v = w; cfg_core = core; cfg_addr = addr; cfg_data = data;
    for (int i = 0; i < 20 && cfg_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    if (cfg_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: cfg_ready_o=%b, expected 1 within 20 cycles", cfg_ready);
      cfg_v = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cfg_v = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("resp_drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset_n = 1'b1; my_core_id = 8'd3; resp_ready = 1'b1;
    cfg_v = 1'b0; cfg_w_v = 1'b0; cfg_core = '0; cfg_addr = '0; cfg_data = '0;

    vecs.push_back(vec_t'{1, 8'h02, 16'h0002, 64'd3, 0, CHK_ICACHE, 64'd0});
    vecs.push_back(vec_t'{1, 8'h03, 16'h0001, 64'h80000124, 0, CHK_NPC, 64'h80000124});
    vecs.push_back(vec_t'{1, 8'hFF, 16'h0000, 64'd0, 0, CHK_FREEZE, 64'd0});
    vecs.push_back(vec_t'{0, 8'hFF, 16'h0000, 64'd0, 0, CHK_READY, 64'd1});
    vecs.push_back(vec_t'{1, 8'h03, 16'h0002, 64'd3, 0, CHK_ICACHE, 64'd3});
    vecs.push_back(vec_t'{1, 8'h03, 16'h0003, 64'd2, 0, CHK_DCACHE, 64'd2});
    vecs.push_back(vec_t'{1, 8'h03, 16'h0004, 64'd1, 0, CHK_CCE, 64'd1});
    vecs.push_back(vec_t'{0, 8'h03, 16'h0002, 64'd0, 1, CHK_NONE, 64'd3});
    vecs.push_back(vec_t'{0, 8'h03, 16'h0001, 64'd0, 1, CHK_NONE, 64'h80000124});
    vecs.push_back(vec_t'{0, 8'h03, 16'h0000, 64'd0, 1, CHK_NONE, 64'd0});
    vecs.push_back(vec_t'{1, 8'h03, 16'h0000, 64'd1, 0, CHK_FREEZE, 64'd1});
    vecs.push_back(vec_t'{0, 8'h03, 16'h0000, 64'd0, 1, CHK_NONE, 64'd1});
    vecs.push_back(vec_t'{1, 8'h03, 16'h0005, 64'hDEADBEEF_CAFEF00D, 0, CHK_ERR, 64'd0});
    vecs.push_back(vec_t'{0, 8'h03, 16'h0005, 64'd0, 1, CHK_NONE, 64'hDEADBEEF_CAFEF00D});
    vecs.push_back(vec_t'{0, 8'h02, 16'h0005, 64'd0, 0, CHK_READY, 64'd1});
    vecs.push_back(vec_t'{1, 8'hFF, 16'h0003, 64'd1, 0, CHK_DCACHE, 64'd1});
    vecs.push_back(vec_t'{0, 8'h03, 16'h0003, 64'd0, 1, CHK_NONE, 64'd1});
    vecs.push_back(vec_t'{1, 8'h03, 16'h0009, 64'd7, 0, CHK_ERR, 64'd1});
    vecs.push_back(vec_t'{0, 8'h03, 16'h0006, 64'd0, 1, CHK_NONE, 64'd1});
    vecs.push_back(vec_t'{0, 8'h03, 16'h000A, 64'd0, 1, CHK_NONE, 64'd0});
    vecs.push_back(vec_t'{1, 8'h03, 16'h0006, 64'd0, 0, CHK_ERR, 64'd0});
    vecs.push_back(vec_t'{0, 8'h03, 16'h0006, 64'd0, 1, CHK_NONE, 64'd0});
    vecs.push_back(vec_t'{1, 8'h03, 16'h1006, 64'd5, 0, CHK_ERR, 64'd1});
    vecs.push_back(vec_t'{1, 8'hFF, 16'h0006, 64'd0, 0, CHK_ERR, 64'd0});
    vecs.push_back(vec_t'{1, 8'h03, 16'h0001, 64'hFFFFFFFF_FFFFFFFF, 0, CHK_NPC, 64'h7F_FFFFFFFF});
    vecs.push_back(vec_t'{0, 8'h03, 16'h0001, 64'd0, 1, CHK_NONE, 64'h7F_FFFFFFFF});
    vecs.push_back(vec_t'{0, 8'h03, 16'h0004, 64'd0, 1, CHK_NONE, 64'd1});

    // Reset state
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_freeze", {63'b0, freeze}, 64'd1);
    check("rst_npc", 64'(npc), 64'd0);
    check("rst_npc_w_v", {63'b0, npc_w_v}, 64'd0);
    check("rst_modes", {59'b0, icache_mode, dcache_mode, cce_mode}, 64'd0);
    check("rst_err", {63'b0, err}, 64'd0);
    check("rst_resp_v", {63'b0, resp_v}, 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_ready", {63'b0, cfg_ready}, 64'd0);
    reset_n = 1'b1;
    check("ready_before_edge", {63'b0, cfg_ready}, 64'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {63'b0, cfg_ready}, 64'd1);

    foreach (vecs[i]) begin
      if (vecs[i].exp_resp) exp_q.push_back(vecs[i].exp);
      send(vecs[i].w, vecs[i].core, vecs[i].addr, vecs[i].data);
      if (!vecs[i].w) begin
        drain();
        if (!vecs[i].exp_resp) begin
          repeat (2) @(negedge clk);
          check($sformatf("vec%0d_no_resp_v", i), {63'b0, resp_v}, 64'd0);
        end
      end
      if (vecs[i].chk != CHK_NONE) begin
        @(negedge clk);
        check($sformatf("vec%0d_out", i), out_of(vecs[i].chk), vecs[i].exp);
      end
      @(posedge clk); #1;
    end

    // npc write pulse lasts exactly one cycle
    send(1'b1, 8'h03, 16'h0001, 64'h1000);
    check("npc_pulse_hi", {63'b0, npc_w_v}, 64'd1);
    check("npc_value", 64'(npc), 64'h1000);
    @(posedge clk); #1;
    check("npc_pulse_lo", {63'b0, npc_w_v}, 64'd0);

    // Back-to-back writes on consecutive cycles
    cfg_v = 1'b1; cfg_w_v = 1'b1; cfg_core = 8'h03; cfg_addr = 16'h0002; cfg_data = 64'd1;
    check("b2b_ready", {63'b0, cfg_ready}, 64'd1);
    @(posedge clk); #1;
    cfg_addr = 16'h0003; cfg_data = 64'd2;
    @(posedge clk); #1;
    cfg_v = 1'b0;
    check("b2b_icache", {62'b0, icache_mode}, 64'd1);
    check("b2b_dcache", {62'b0, dcache_mode}, 64'd2);

    // Held response under back-pressure
    resp_ready = 1'b0;
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    send(1'b0, 8'h03, 16'h0005, 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_resp_v", c), {63'b0, resp_v}, 64'd1);
      check($sformatf("stall%0d_data", c), resp_data, 64'hDEADBEEF_CAFEF00D);
      check($sformatf("stall%0d_ready", c), {63'b0, cfg_ready}, 64'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_ready", {63'b0, cfg_ready}, 64'd1);
    check("stall_release_resp_v", {63'b0, resp_v}, 64'd0);
    drain();

    // Reset while a response is pending discards it
    resp_ready = 1'b0;
    send(1'b0, 8'h03, 16'h0000, 64'd0);
    @(negedge clk);
    check("pre_rst_resp_v", {63'b0, resp_v}, 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_resp_v", {63'b0, resp_v}, 64'd0);
    check("mid_rst_freeze", {63'b0, freeze}, 64'd1);
    check("mid_rst_ready", {63'b0, cfg_ready}, 64'd0);
    check("mid_rst_npc", 64'(npc), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {63'b0, cfg_ready}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_resp_v", {63'b0, resp_v}, 64'd0);
    check("post_rst_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
